wb_byte_bridge_master: RTL

- Byte-stream to Wishbone pipelined master; the initiator end of the Wishbone slave ports on the SoC interconnect.
- Takes framed commands from a host byte link (UART RX/TX or JTAG FIFO, valid/ready) and issues single 32-bit reads/writes.
- Returns a status byte, plus read data for reads.
- Used for program loading into instruction/data memory and for debug peeking, as an alternative master beside the core's data port.

---
 rtl/wb_byte_bridge_master.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/wb_byte_bridge_master.sv
// Byte-link command decoder acting as a single-outstanding Wishbone
// pipelined master: frames in on RX, status (+ read data) out on TX.
module wb_byte_bridge_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  OP_WRITE       = 8'h01,
    parameter logic [7:0]  OP_READ        = 8'h02
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_err_i,
    output logic        busy_o
);

    localparam int unsigned   CW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    localparam logic [7:0] ST_OK  = 8'h00;
    localparam logic [7:0] ST_ERR = 8'hEE;
    localparam logic [7:0] ST_TMO = 8'hDD;
    localparam logic [7:0] ST_BAD = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        r_state;
    logic [1:0]    r_nbyte;
    logic          r_is_wr;
    logic [CW-1:0] r_tmo;
    logic [31:0]   r_shift;
    logic [2:0]    r_left;

    state_t        w_state;
    logic [1:0]    w_nbyte;
    logic          w_is_wr;
    logic [CW-1:0] w_tmo;
    logic [CW-1:0] w_tmo_inc;
    logic [31:0]   w_shift;
    logic [2:0]    w_left;
    logic [31:0]   w_adr;
    logic [31:0]   w_dat;
    logic [7:0]    w_tx_data;
    logic          w_rx_fire;
    logic          w_tx_fire;
    logic          w_in_cyc;

    always_comb begin
        w_rx_fire = rx_valid_i & rx_ready_o;
        w_tx_fire = tx_valid_o & tx_ready_i;
        w_tmo_inc = (r_tmo == TMO) ? r_tmo : r_tmo + CW'(1);
        w_state   = r_state;
        w_nbyte   = r_nbyte;
        w_is_wr   = r_is_wr;
        w_tmo     = r_tmo;
        w_shift   = r_shift;
        w_left    = r_left;
        w_adr     = wb_adr_o;
        w_dat     = wb_dat_o;
        w_tx_data = tx_data_o;

        unique case (r_state)
            S_IDLE: begin
                if (w_rx_fire) begin
                    w_nbyte = 2'd0;
                    if (rx_data_i == OP_WRITE || rx_data_i == OP_READ) begin
                        w_is_wr = (rx_data_i == OP_WRITE);
                        w_state = S_ADDR;
                    end else begin
                        w_tx_data = ST_BAD;
                        w_left    = 3'd0;
                        w_state   = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (w_rx_fire) begin
                    w_adr   = {rx_data_i, wb_adr_o[31:8]};
                    w_nbyte = r_nbyte + 2'd1;
                    if (r_nbyte == 2'd3) begin
                        w_tmo   = '0;
                        w_state = r_is_wr ? S_DATA : S_REQ;
                    end
                end
            end
            S_DATA: begin
                if (w_rx_fire) begin
                    w_dat   = {rx_data_i, wb_dat_o[31:8]};
                    w_nbyte = r_nbyte + 2'd1;
                    if (r_nbyte == 2'd3) begin
                        w_tmo   = '0;
                        w_state = S_REQ;
                    end
                end
            end
            S_REQ, S_WAIT: begin
                w_tmo = w_tmo_inc;
                // err outranks ack; either one ends the cycle even under stall
                if (wb_err_i) begin
                    w_tx_data = ST_ERR;
                    w_left    = 3'd0;
                    w_state   = S_RESP;
                end else if (wb_ack_i) begin
                    w_tx_data = ST_OK;
                    w_left    = r_is_wr ? 3'd0 : 3'd4;
                    w_shift   = wb_dat_i;
                    w_state   = S_RESP;
                end else if (w_tmo_inc == TMO) begin
                    w_tx_data = ST_TMO;
                    w_left    = 3'd0;
                    w_state   = S_RESP;
                end else if (r_state == S_REQ && !wb_stall_i) begin
                    w_state = S_WAIT;
                end
            end
            S_RESP: begin
                if (w_tx_fire) begin
                    if (r_left != 3'd0) begin
                        w_tx_data = r_shift[7:0];
                        w_shift   = {8'h00, r_shift[31:8]};
                        w_left    = r_left - 3'd1;
                    end else begin
                        w_state = S_IDLE;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase

        w_in_cyc = (w_state == S_REQ) || (w_state == S_WAIT);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state    <= S_IDLE;
            r_nbyte    <= 2'd0;
            r_is_wr    <= 1'b0;
            r_tmo      <= '0;
            r_shift    <= 32'h0;
            r_left     <= 3'd0;
            rx_ready_o <= 1'b1;
            tx_data_o  <= 8'h00;
            tx_valid_o <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= 32'h0;
            wb_dat_o   <= 32'h0;
            wb_sel_o   <= 4'h0;
            busy_o     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_nbyte    <= w_nbyte;
            r_is_wr    <= w_is_wr;
            r_tmo      <= w_tmo;
            r_shift    <= w_shift;
            r_left     <= w_left;
            rx_ready_o <= (w_state == S_IDLE) || (w_state == S_ADDR) ||
                          (w_state == S_DATA);
            tx_data_o  <= w_tx_data;
            tx_valid_o <= (w_state == S_RESP);
            wb_cyc_o   <= w_in_cyc;
            wb_stb_o   <= (w_state == S_REQ);
            wb_we_o    <= w_in_cyc & w_is_wr;
            wb_adr_o   <= w_adr;
            wb_dat_o   <= w_dat;
            wb_sel_o   <= w_in_cyc ? 4'hF : 4'h0;
            busy_o     <= (w_state != S_IDLE);
        end
    end

endmodule
